// File: rtl/vote_round_ctrl.sv
// Sequences one 4-voter ballot round: opens on start, collects first ballots per voter,
// closes on full vote or timeout, then reports the 3-of-4 majority with a done pulse.
module vote_round_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int TW      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] cast,
    input  logic [3:0] ballot,
    output logic       busy,
    output logic [3:0] voted,
    output logic       done,
    output logic       pass,
    output logic [2:0] count,
    output logic       timed_out
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DECIDE  = 2'd2
    } state_t;

    localparam logic [TW-1:0] LP_LAST = TW'(TIMEOUT - 1);

    state_t          r_state;
    state_t          w_next;
    logic [TW-1:0]   r_timer;
    logic [3:0]      r_voted;
    logic [3:0]      r_yes;
    logic            r_to_pend;
    logic            r_done;
    logic            r_pass;
    logic [2:0]      r_count;
    logic            r_timed_out;

    logic [3:0]      w_accept;
    logic [3:0]      w_voted_new;
    logic            w_all;
    logic            w_tmo;
    logic [2:0]      w_yes_cnt;

    // Only voters not yet recorded can be accepted, so the first ballot wins.
    assign w_accept    = cast & ~r_voted;
    assign w_voted_new = r_voted | w_accept;
    assign w_all       = &w_voted_new;
    assign w_tmo       = (r_timer == LP_LAST);
    assign w_yes_cnt   = {2'b00, r_yes[0]} + {2'b00, r_yes[1]}
                       + {2'b00, r_yes[2]} + {2'b00, r_yes[3]};

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: w_next gets a default first so no path through the case infers a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = S_COLLECT;
            S_COLLECT: if (w_all || w_tmo) w_next = S_DECIDE;
            S_DECIDE:  w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer     <= '0;
            r_voted     <= '0;
            r_yes       <= '0;
            r_to_pend   <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_count     <= '0;
            r_timed_out <= 1'b0;
        end else begin
            r_done <= (r_state == S_DECIDE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_voted <= '0;
                        r_yes   <= '0;
                        r_timer <= '0;
                    end
                end
                S_COLLECT: begin
                    r_voted <= w_voted_new;
                    r_yes   <= r_yes | (w_accept & ballot);
                    r_timer <= r_timer + TW'(1);
                    // A full vote on the timeout edge still counts as a normal close.
                    if (w_all || w_tmo) r_to_pend <= ~w_all;
                end
                S_DECIDE: begin
                    r_count     <= w_yes_cnt;
                    r_pass      <= (w_yes_cnt >= 3'd3);
                    r_timed_out <= r_to_pend;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign voted     = r_voted;
    assign done      = r_done;
    assign pass      = r_pass;
    assign count     = r_count;
    assign timed_out = r_timed_out;

endmodule

// File: tb/tb_vote_round_ctrl.sv
// Directed bench for vote_round_ctrl: hand-computed expectations, sampled 1ns after each rising edge.
module tb_vote_round_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] cast;
    logic [3:0] ballot;
    logic       busy;
    logic [3:0] voted;
    logic       done;
    logic       pass;
    logic [2:0] count;
    logic       timed_out;

    int n_checks = 0;
    int n_errors = 0;

    vote_round_ctrl #(.TIMEOUT(15), .TW(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .cast     (cast),
        .ballot   (ballot),
        .busy     (busy),
        .voted    (voted),
        .done     (done),
        .pass     (pass),
        .count    (count),
        .timed_out(timed_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_result(input string tag, input logic d, input logic p,
                                input logic [2:0] c, input logic t);
        check({tag, ".done"}, {7'd0, done}, {7'd0, d});
        check({tag, ".pass"}, {7'd0, pass}, {7'd0, p});
        check({tag, ".count"}, {5'd0, count}, {5'd0, c});
        check({tag, ".timed_out"}, {7'd0, timed_out}, {7'd0, t});
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        cast   = 4'b0000;
        ballot = 4'b0000;
        tick(2);
        check("rst.busy", {7'd0, busy}, 8'd0);
        check("rst.voted", {4'd0, voted}, 8'd0);
        check_result("rst", 1'b0, 1'b0, 3'd0, 1'b0);
        rst_n = 1'b1;
        tick(1);

        // 1: fastest round, ballots 1101
        start = 1'b1;
        tick(1);                                   // E0
        start = 1'b0;
        check("t1.busy_e0", {7'd0, busy}, 8'd1);
        cast = 4'b1111; ballot = 4'b1101;
        tick(1);                                   // E1
        cast = 4'b0000; ballot = 4'b0000;
        check("t1.voted_e1", {4'd0, voted}, 8'h0f);
        check("t1.done_e1", {7'd0, done}, 8'd0);
        tick(1);                                   // E2
        check_result("t1", 1'b1, 1'b1, 3'd3, 1'b0);
        check("t1.busy_e2", {7'd0, busy}, 8'd0);

        // start accepted while done is high
        start = 1'b1;
        tick(1);                                   // E0 of round 2
        start = 1'b0;
        check("t2.done_clears", {7'd0, done}, 8'd0);
        check("t2.pass_held", {7'd0, pass}, 8'd1);
        check("t2.busy", {7'd0, busy}, 8'd1);
        check("t2.voted_cleared", {4'd0, voted}, 8'd0);

        // 2: serial votes yes, yes, no, no
        cast = 4'b0001; ballot = 4'b0001; tick(1);
        cast = 4'b0010; ballot = 4'b0010; tick(1);
        cast = 4'b0100; ballot = 4'b0000; tick(1);
        cast = 4'b1000; ballot = 4'b0000; tick(1); // Ek
        cast = 4'b0000;
        check("t2.done_ek", {7'd0, done}, 8'd0);
        tick(1);                                   // Ek+1
        check_result("t2", 1'b1, 1'b0, 3'd2, 1'b0);
        check("t2.voted", {4'd0, voted}, 8'h0f);

        // 3: timeout with voters 0-2 yes, voter 3 silent
        start = 1'b1; tick(1); start = 1'b0;       // E0
        cast = 4'b0111; ballot = 4'b0111; tick(1); // E1
        cast = 4'b0000; ballot = 4'b0000;
        tick(14);                                  // E15
        check("t3.done_e15", {7'd0, done}, 8'd0);
        check("t3.busy_e15", {7'd0, busy}, 8'd1);
        tick(1);                                   // E16
        check_result("t3", 1'b1, 1'b1, 3'd3, 1'b1);
        check("t3.voted", {4'd0, voted}, 8'h07);

        // 4: voter 0 recasts no; first yes ballot wins
        start = 1'b1; tick(1); start = 1'b0;
        cast = 4'b0001; ballot = 4'b0001; tick(1);
        cast = 4'b0000; ballot = 4'b0000; tick(1);
        cast = 4'b0001; ballot = 4'b0000; tick(1);
        cast = 4'b1110; ballot = 4'b0000; tick(1);
        cast = 4'b0000;
        tick(1);
        check_result("t4", 1'b1, 1'b0, 3'd1, 1'b0);

        // 5a: last cast lands on the timeout edge
        start = 1'b1; tick(1); start = 1'b0;       // E0
        cast = 4'b0111; ballot = 4'b0111; tick(1); // E1
        cast = 4'b0000; ballot = 4'b0000;
        tick(13);                                  // E14
        check("t5a.busy_e14", {7'd0, busy}, 8'd1);
        cast = 4'b1000; ballot = 4'b1000; tick(1); // E15, timer==14
        cast = 4'b0000; ballot = 4'b0000;
        check("t5a.done_e15", {7'd0, done}, 8'd0);
        tick(1);                                   // E16
        check_result("t5a", 1'b1, 1'b1, 3'd4, 1'b0);

        // 6: reset mid-COLLECT abandons the round
        start = 1'b1; tick(1); start = 1'b0;
        cast = 4'b0011; ballot = 4'b0011; tick(1);
        cast = 4'b0000; ballot = 4'b0000;
        check("t6.voted_pre", {4'd0, voted}, 8'h03);
        rst_n = 1'b0;
        #1;
        check("t6.busy_rst", {7'd0, busy}, 8'd0);
        check("t6.voted_rst", {4'd0, voted}, 8'd0);
        check_result("t6_rst", 1'b0, 1'b0, 3'd0, 1'b0);
        tick(1);
        rst_n = 1'b1;
        tick(3);
        check("t6.no_done", {7'd0, done}, 8'd0);

        // 6: casts in IDLE are ignored
        cast = 4'b1111; ballot = 4'b1111; tick(2);
        cast = 4'b0000; ballot = 4'b0000;
        check("t6.idle_voted", {4'd0, voted}, 8'd0);
        check("t6.idle_busy", {7'd0, busy}, 8'd0);

        // 5b: start pulsed mid-COLLECT does not restart the round or its timer
        start = 1'b1; tick(1); start = 1'b0;       // E0
        cast = 4'b0001; ballot = 4'b0000; tick(1); // E1
        cast = 4'b0000;
        tick(1);                                   // E2
        start = 1'b1; tick(1); start = 1'b0;       // E3
        check("t5b.voted_kept", {4'd0, voted}, 8'h01);
        tick(12);                                  // E15
        check("t5b.done_e15", {7'd0, done}, 8'd0);
        tick(1);                                   // E16
        check_result("t5b", 1'b1, 1'b0, 3'd0, 1'b1);
        check("t5b.voted", {4'd0, voted}, 8'h01);
        tick(1);
        check("t5b.done_pulse", {7'd0, done}, 8'd0);
        check("t5b.busy_after", {7'd0, busy}, 8'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
